// File: rtl/pcs_transmit_if.sv
// rtl/pcs_transmit_if.sv - GMII transmit octet stream in, 10-bit code group stream out
//   TX_EN, TX_ER, TXD : GMII transmit enable, error and octet (driven by the MAC side)
//   tx_code_group     : registered 10-bit code group, bit 9 = a .. bit 0 = j
//   tx_even           : high when tx_code_group sits in an even slot
//   tx_disparity      : running disparity after tx_code_group (1 = RD+)
//   transmitting      : high while /S/, data or /V/ is on tx_code_group
//   modport master : MAC / bench side, modport slave : PCS transmit side
interface pcs_transmit_if;
    logic       TX_EN;
    logic       TX_ER;
    logic [7:0] TXD;
    logic [9:0] tx_code_group;
    logic       tx_even;
    logic       tx_disparity;
    logic       transmitting;

    modport master (
        output TX_EN, TX_ER, TXD,
        input  tx_code_group, tx_even, tx_disparity, transmitting
    );

    modport slave (
        input  TX_EN, TX_ER, TXD,
        output tx_code_group, tx_even, tx_disparity, transmitting
    );
endinterface

// File: rtl/pcs_transmit.sv
// rtl/pcs_transmit.sv - 1000BASE-X PCS transmit: framing, idle generation and 8b/10b encoding
//   clk  : transmit clock, one code group per rising edge
//   rst  : asynchronous active-low reset
//   gmii : pcs_transmit_if.slave (GMII octet in, code group / slot parity / RD / transmitting out)
//   Optional build macro PCS_TX_ERRPROP_EN: TX_ER with TX_EN replaces the octet with /V/ (K30.7).
module pcs_transmit (
    input  logic          clk,
    input  logic          rst,
    pcs_transmit_if.slave gmii
);

    // state names the kind of code group currently on tx_code_group
    typedef enum logic [2:0] {
        ST_IDLE_K,
        ST_IDLE_D,
        ST_SOP,
        ST_DATA,
        ST_EOP_T,
        ST_EOP_R1,
        ST_EOP_R2
    } state_t;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K27_7 = 8'hFB;
    localparam logic [7:0] K29_7 = 8'hFD;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] K30_7 = 8'hFE;
    localparam logic [7:0] D16_2 = 8'h50;
    localparam logic [7:0] D5_6  = 8'hC5;

    state_t      state;
    state_t      next_state;
    logic [7:0]  enc_octet;
    logic        enc_k;
    logic        to_even;
    logic        frame_err;
    logic [10:0] enc_result;

`ifdef PCS_TX_ERRPROP_EN
    assign frame_err = gmii.TX_ER;
`else
    logic unused_tx_er;
    assign frame_err    = 1'b0;
    assign unused_tx_er = gmii.TX_ER;
`endif

    // 5b/6b sub-block: returns {rd_after, abcdei}. Table holds the RD- form;
    // the RD+ form is the complement for unbalanced codes and for D.7.
    function automatic logic [6:0] enc_5b6b(input logic [4:0] x, input logic k, input logic rd);
        logic [5:0] base;
        logic       unbal;
        logic       flip;
        if (k && x == 5'd28) begin
            base = 6'b001111;
        end else begin
            case (x)
                5'd0:  base = 6'b100111;
                5'd1:  base = 6'b011101;
                5'd2:  base = 6'b101101;
                5'd3:  base = 6'b110001;
                5'd4:  base = 6'b110101;
                5'd5:  base = 6'b101001;
                5'd6:  base = 6'b011001;
                5'd7:  base = 6'b111000;
                5'd8:  base = 6'b111001;
                5'd9:  base = 6'b100101;
                5'd10: base = 6'b010101;
                5'd11: base = 6'b110100;
                5'd12: base = 6'b001101;
                5'd13: base = 6'b101100;
                5'd14: base = 6'b011100;
                5'd15: base = 6'b010111;
                5'd16: base = 6'b011011;
                5'd17: base = 6'b100011;
                5'd18: base = 6'b010011;
                5'd19: base = 6'b110010;
                5'd20: base = 6'b001011;
                5'd21: base = 6'b101010;
                5'd22: base = 6'b011010;
                5'd23: base = 6'b111010;
                5'd24: base = 6'b110011;
                5'd25: base = 6'b100110;
                5'd26: base = 6'b010110;
                5'd27: base = 6'b110110;
                5'd28: base = 6'b001110;
                5'd29: base = 6'b101110;
                5'd30: base = 6'b011110;
                default: base = 6'b101011;
            endcase
        end
        unbal = ($countones(base) != 3);
        flip  = rd && (unbal || (!k && x == 5'd7));
        return {rd ^ unbal, flip ? ~base : base};
    endfunction

    // 3b/4b sub-block: returns {rd_after, fghj}. rd is the disparity after the 6b block.
    // K.x.7 always uses the alternate form; D.x.7 uses it only where P7 would
    // create a run of five identical bits across the sub-block boundary.
    function automatic logic [4:0] enc_3b4b(input logic [2:0] y, input logic [4:0] x,
                                            input logic k, input logic rd);
        logic [3:0] base;
        logic       use_a7;
        logic       special;
        logic       unbal;
        logic       flip;
        use_a7 = k || (!rd && (x == 5'd17 || x == 5'd18 || x == 5'd20))
                   || (rd && (x == 5'd11 || x == 5'd13 || x == 5'd14));
        case (y)
            3'd0:    base = 4'b1011;
            3'd1:    base = 4'b1001;
            3'd2:    base = 4'b0101;
            3'd3:    base = 4'b1100;
            3'd4:    base = 4'b1101;
            3'd5:    base = k ? 4'b0101 : 4'b1010;
            3'd6:    base = 4'b0110;
            default: base = use_a7 ? 4'b0111 : 4'b1110;
        endcase
        // balanced groups whose bit pattern still depends on RD
        special = (!k && y == 3'd3) || (k && y == 3'd5);
        unbal   = ($countones(base) != 2);
        flip    = rd && (unbal || special);
        return {rd ^ unbal, flip ? ~base : base};
    endfunction

    // returns {rd_after, abcdeifghj}
    function automatic logic [10:0] encode_8b10b(input logic [7:0] octet, input logic k, input logic rd);
        logic [6:0] s6;
        logic [4:0] s4;
        s6 = enc_5b6b(octet[4:0], k, rd);
        s4 = enc_3b4b(octet[7:5], octet[4:0], k, s6[6]);
        return {s4[4], s6[5:0], s4[3:0]};
    endfunction

    always_comb begin
        next_state = state;
        enc_octet  = K28_5;
        enc_k      = 1'b1;
        to_even    = 1'b0;
        case (state)
            ST_IDLE_K: begin
                // K28.5 always flips RD, so RD+ now means RD- was held before it
                next_state = ST_IDLE_D;
                enc_k      = 1'b0;
                enc_octet  = gmii.tx_disparity ? D16_2 : D5_6;
            end
            ST_SOP, ST_DATA: begin
                if (gmii.TX_EN) begin
                    next_state = ST_DATA;
                    if (frame_err) begin
                        enc_octet = K30_7;
                    end else begin
                        enc_octet = gmii.TXD;
                        enc_k     = 1'b0;
                    end
                end else begin
                    next_state = ST_EOP_T;
                    enc_octet  = K29_7;
                end
            end
            ST_EOP_T: begin
                next_state = ST_EOP_R1;
                enc_octet  = K23_7;
            end
            ST_EOP_R1: begin
                // a first /R/ in an even slot needs a second one to realign
                if (gmii.tx_even) begin
                    next_state = ST_EOP_R2;
                    enc_octet  = K23_7;
                end else begin
                    to_even = 1'b1;
                end
            end
            default: begin
                to_even = 1'b1;
            end
        endcase

        // the coming slot is even: either a frame start or the next idle ordered set
        if (to_even) begin
            if (gmii.TX_EN) begin
                next_state = ST_SOP;
                enc_octet  = frame_err ? K30_7 : K27_7;
            end else begin
                next_state = ST_IDLE_K;
                enc_octet  = K28_5;
            end
        end
    end

    assign enc_result = encode_8b10b(enc_octet, enc_k, gmii.tx_disparity);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= ST_IDLE_K;
            gmii.tx_code_group <= 10'b0011111010;
            gmii.tx_even       <= 1'b1;
            gmii.tx_disparity  <= 1'b1;
            gmii.transmitting  <= 1'b0;
        end else begin
            state              <= next_state;
            gmii.tx_code_group <= enc_result[9:0];
            gmii.tx_disparity  <= enc_result[10];
            gmii.tx_even       <= ~gmii.tx_even;
            gmii.transmitting  <= (next_state == ST_SOP) || (next_state == ST_DATA);
        end
    end

endmodule

// File: tb/tb_pcs_transmit.sv
// tb/tb_pcs_transmit.sv - directed and property checks for pcs_transmit
module tb_pcs_transmit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    pcs_transmit_if tx_if ();

    pcs_transmit dut (
        .clk  (clk),
        .rst  (rst),
        .gmii (tx_if)
    );

    always #5 clk = ~clk;

    // inputs change on the falling edge; outputs are read at the next falling edge
    task automatic drive(input logic en, input logic er, input logic [7:0] d);
        tx_if.TX_EN = en;
        tx_if.TX_ER = er;
        tx_if.TXD   = d;
        @(negedge clk);
    endtask

    task automatic do_reset;
        tx_if.TX_EN = 1'b0;
        tx_if.TX_ER = 1'b0;
        tx_if.TXD   = 8'h00;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        tx_if.TX_EN = 1'b1;
        tx_if.TX_ER = 1'b1;
        tx_if.TXD   = 8'hFF;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (tx_if.tx_code_group !== 10'b0011111010) begin
            mismatched++;
            $display("FAIL reset code group: got %b expected 0011111010", tx_if.tx_code_group);
        end
        compared++;
        if (tx_if.tx_even !== 1'b1) begin
            mismatched++;
            $display("FAIL reset tx_even: got %b expected 1", tx_if.tx_even);
        end
        compared++;
        if (tx_if.tx_disparity !== 1'b1) begin
            mismatched++;
            $display("FAIL reset tx_disparity: got %b expected 1", tx_if.tx_disparity);
        end
        compared++;
        if (tx_if.transmitting !== 1'b0) begin
            mismatched++;
            $display("FAIL reset transmitting: got %b expected 0", tx_if.transmitting);
        end
    endtask

    task automatic test_idle;
        logic [9:0] exp_cg;
        do_reset;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, i[0], 8'(i * 37));
            exp_cg = (i % 2 == 1) ? 10'b1001000101 : 10'b0011111010;
            compared++;
            if (tx_if.tx_code_group !== exp_cg) begin
                mismatched++;
                $display("FAIL idle slot %0d code group: got %b expected %b", i, tx_if.tx_code_group, exp_cg);
            end
            compared++;
            if (tx_if.tx_even !== (i % 2 == 0)) begin
                mismatched++;
                $display("FAIL idle slot %0d tx_even: got %b expected %b", i, tx_if.tx_even, (i % 2 == 0));
            end
            compared++;
            if (tx_if.tx_disparity !== (i % 2 == 0)) begin
                mismatched++;
                $display("FAIL idle slot %0d tx_disparity: got %b expected %b", i, tx_if.tx_disparity, (i % 2 == 0));
            end
            compared++;
            if (tx_if.transmitting !== 1'b0) begin
                mismatched++;
                $display("FAIL idle slot %0d transmitting: got %b expected 0", i, tx_if.transmitting);
            end
        end
    endtask

    // /S/ in slot 2, four data octets, /T/ /R/ /R/, idle at RD+ (K28.5 RD+ then D5.6)
    task automatic test_frame_even;
        bit         en_v [11];
        logic [7:0] d_v  [11];
        logic [9:0] cg_v [11];
        bit         rd_v [11];
        bit         tx_v [11];
        en_v = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        d_v  = '{8'h00, 8'h55, 8'h55, 8'hD5, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        cg_v = '{10'b1001000101, 10'b1101101000, 10'b1010100101, 10'b1010100110,
                 10'b0101011010, 10'b1101101010, 10'b0100010111, 10'b0001010111,
                 10'b0001010111, 10'b1100000101, 10'b1010010110};
        rd_v = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        tx_v = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        do_reset;
        for (int i = 0; i < 11; i++) begin
            drive(en_v[i], 1'b0, d_v[i]);
            compared++;
            if (tx_if.tx_code_group !== cg_v[i]) begin
                mismatched++;
                $display("FAIL frame_even slot %0d code group: got %b expected %b", i + 1, tx_if.tx_code_group, cg_v[i]);
            end
            compared++;
            if (tx_if.tx_disparity !== rd_v[i]) begin
                mismatched++;
                $display("FAIL frame_even slot %0d tx_disparity: got %b expected %b", i + 1, tx_if.tx_disparity, rd_v[i]);
            end
            compared++;
            if (tx_if.transmitting !== tx_v[i]) begin
                mismatched++;
                $display("FAIL frame_even slot %0d transmitting: got %b expected %b", i + 1, tx_if.transmitting, tx_v[i]);
            end
            compared++;
            if (tx_if.tx_even !== (i % 2 == 1)) begin
                mismatched++;
                $display("FAIL frame_even slot %0d tx_even: got %b expected %b", i + 1, tx_if.tx_even, (i % 2 == 1));
            end
        end
    endtask

    // TX_EN rises in an odd slot: first octet dropped, five data octets, single /R/
    task automatic test_frame_odd;
        bit         en_v [10];
        logic [7:0] d_v  [10];
        logic [9:0] cg_v [10];
        bit         rd_v [10];
        bit         tx_v [10];
        en_v = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        d_v  = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00};
        cg_v = '{10'b1001000101, 10'b1101101000, 10'b1010100101, 10'b1010100101,
                 10'b1010100110, 10'b0101011010, 10'b1101101010, 10'b0100010111,
                 10'b0001010111, 10'b1100000101};
        rd_v = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        tx_v = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        do_reset;
        for (int i = 0; i < 10; i++) begin
            drive(en_v[i], 1'b0, d_v[i]);
            compared++;
            if (tx_if.tx_code_group !== cg_v[i]) begin
                mismatched++;
                $display("FAIL frame_odd slot %0d code group: got %b expected %b", i + 1, tx_if.tx_code_group, cg_v[i]);
            end
            compared++;
            if (tx_if.tx_disparity !== rd_v[i]) begin
                mismatched++;
                $display("FAIL frame_odd slot %0d tx_disparity: got %b expected %b", i + 1, tx_if.tx_disparity, rd_v[i]);
            end
            compared++;
            if (tx_if.transmitting !== tx_v[i]) begin
                mismatched++;
                $display("FAIL frame_odd slot %0d transmitting: got %b expected %b", i + 1, tx_if.transmitting, tx_v[i]);
            end
        end
    endtask

    // D.x.7 primary/alternate choice, D.7 and D.x.3 RD-dependent forms
    task automatic test_data_codes;
        bit         en_v [12];
        logic [7:0] d_v  [12];
        logic [9:0] cg_v [12];
        bit         rd_v [12];
        en_v = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        d_v  = '{8'h00, 8'h55, 8'hF1, 8'hEB, 8'h07, 8'h07, 8'hE7, 8'hF1, 8'h63, 8'h00, 8'h00, 8'h00};
        cg_v = '{10'b1001000101, 10'b1101101000, 10'b1000110111, 10'b1101001000,
                 10'b1110001011, 10'b0001110100, 10'b1110001110, 10'b1000110001,
                 10'b1100011100, 10'b1011101000, 10'b1110101000, 10'b0011111010};
        rd_v = '{0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1};
        do_reset;
        for (int i = 0; i < 12; i++) begin
            drive(en_v[i], 1'b0, d_v[i]);
            compared++;
            if (tx_if.tx_code_group !== cg_v[i]) begin
                mismatched++;
                $display("FAIL data_codes slot %0d code group: got %b expected %b", i + 1, tx_if.tx_code_group, cg_v[i]);
            end
            compared++;
            if (tx_if.tx_disparity !== rd_v[i]) begin
                mismatched++;
                $display("FAIL data_codes slot %0d tx_disparity: got %b expected %b", i + 1, tx_if.tx_disparity, rd_v[i]);
            end
        end
    endtask

    // TX_EN high during /T/ and /R/ slots is dropped; next frame starts at the even slot
    task automatic test_back_to_back;
        bit         en_v [13];
        logic [7:0] d_v  [13];
        logic [9:0] cg_v [13];
        bit         rd_v [13];
        bit         tx_v [13];
        en_v = '{0, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        d_v  = '{8'h00, 8'h55, 8'h00, 8'h00, 8'h55, 8'h55, 8'hBC, 8'hE7, 8'h00, 8'h55, 8'h55, 8'h00, 8'h00};
        cg_v = '{10'b1001000101, 10'b1101101000, 10'b1001110100, 10'b1011101000,
                 10'b1110101000, 10'b1101101000, 10'b0011101010, 10'b1110001110,
                 10'b0100010111, 10'b0001010111, 10'b0001010111, 10'b1100000101,
                 10'b1010010110};
        rd_v = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        tx_v = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
        do_reset;
        for (int i = 0; i < 13; i++) begin
            drive(en_v[i], 1'b0, d_v[i]);
            compared++;
            if (tx_if.tx_code_group !== cg_v[i]) begin
                mismatched++;
                $display("FAIL back_to_back slot %0d code group: got %b expected %b", i + 1, tx_if.tx_code_group, cg_v[i]);
            end
            compared++;
            if (tx_if.tx_disparity !== rd_v[i]) begin
                mismatched++;
                $display("FAIL back_to_back slot %0d tx_disparity: got %b expected %b", i + 1, tx_if.tx_disparity, rd_v[i]);
            end
            compared++;
            if (tx_if.transmitting !== tx_v[i]) begin
                mismatched++;
                $display("FAIL back_to_back slot %0d transmitting: got %b expected %b", i + 1, tx_if.transmitting, tx_v[i]);
            end
        end
    endtask

    // TX_ER on the third data octet; TX_ER with TX_EN low in slot 1
    task automatic test_errprop;
        bit         en_v [10];
        bit         er_v [10];
        logic [7:0] d_v  [10];
        logic [9:0] cg_v [10];
        bit         rd_v [10];
        bit         tx_v [10];
        en_v = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        er_v = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        d_v  = '{8'h00, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hAA, 8'h00, 8'h00, 8'h00, 8'h00};
        cg_v = '{10'b1001000101, 10'b1101101000, 10'b1010100101, 10'b1010100101,
`ifdef PCS_TX_ERRPROP_EN
                 10'b0111101000,
`else
                 10'b1010100110,
`endif
                 10'b0101011010, 10'b1011101000, 10'b1110101000, 10'b1110101000,
                 10'b0011111010};
        rd_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        tx_v = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        do_reset;
        for (int i = 0; i < 10; i++) begin
            drive(en_v[i], er_v[i], d_v[i]);
            compared++;
            if (tx_if.tx_code_group !== cg_v[i]) begin
                mismatched++;
                $display("FAIL errprop slot %0d code group: got %b expected %b", i + 1, tx_if.tx_code_group, cg_v[i]);
            end
            compared++;
            if (tx_if.tx_disparity !== rd_v[i]) begin
                mismatched++;
                $display("FAIL errprop slot %0d tx_disparity: got %b expected %b", i + 1, tx_if.tx_disparity, rd_v[i]);
            end
            compared++;
            if (tx_if.transmitting !== tx_v[i]) begin
                mismatched++;
                $display("FAIL errprop slot %0d transmitting: got %b expected %b", i + 1, tx_if.transmitting, tx_v[i]);
            end
        end
    endtask

    // reset dropped between edges in the middle of a frame
    task automatic test_reset_midframe;
        do_reset;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hBB);
        drive(1'b1, 1'b0, 8'hBB);
        #2;
        rst = 1'b0;
        #1;
        compared++;
        if (tx_if.tx_code_group !== 10'b0011111010) begin
            mismatched++;
            $display("FAIL midframe reset code group: got %b expected 0011111010", tx_if.tx_code_group);
        end
        compared++;
        if (tx_if.tx_even !== 1'b1 || tx_if.tx_disparity !== 1'b1 || tx_if.transmitting !== 1'b0) begin
            mismatched++;
            $display("FAIL midframe reset flags: got even=%b rd=%b tx=%b expected even=1 rd=1 tx=0",
                     tx_if.tx_even, tx_if.tx_disparity, tx_if.transmitting);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h55);
        compared++;
        if (tx_if.tx_code_group !== 10'b1001000101 || tx_if.tx_even !== 1'b0 || tx_if.transmitting !== 1'b0) begin
            mismatched++;
            $display("FAIL midframe release slot 1: got cg=%b even=%b tx=%b expected cg=1001000101 even=0 tx=0",
                     tx_if.tx_code_group, tx_if.tx_even, tx_if.transmitting);
        end
    endtask

    // random frames: code-group weight, disparity sign rule and slot parity on every slot
    task automatic test_random_frames;
        logic rd_m;
        logic ev_m;
        logic en;
        logic er;
        int   ones;
        int   gap;
        int   len;
        int   total;
        do_reset;
        rd_m = 1'b1;
        ev_m = 1'b1;
        for (int f = 0; f < 150; f++) begin
            gap   = $urandom_range(0, 5);
            len   = $urandom_range(2, 65);
            total = gap + len + ((f == 149) ? 8 : 0);
            for (int c = 0; c < total; c++) begin
                en = (c >= gap) && (c < gap + len);
                er = ($urandom_range(0, 15) == 0);
                drive(en, er, 8'($urandom));
                ev_m = ~ev_m;
                ones = $countones(tx_if.tx_code_group);
                compared++;
                if (ones < 4 || ones > 6) begin
                    mismatched++;
                    $display("FAIL random frame %0d weight: got %0d ones in %b expected 4..6", f, ones, tx_if.tx_code_group);
                end
                compared++;
                if ((ones == 6 && rd_m) || (ones == 4 && !rd_m)) begin
                    mismatched++;
                    $display("FAIL random frame %0d disparity sign: got %0d ones at RD %b expected a legal group", f, ones, rd_m);
                end
                if (ones == 6) rd_m = 1'b1;
                if (ones == 4) rd_m = 1'b0;
                compared++;
                if (tx_if.tx_disparity !== rd_m) begin
                    mismatched++;
                    $display("FAIL random frame %0d tx_disparity: got %b expected %b", f, tx_if.tx_disparity, rd_m);
                    rd_m = tx_if.tx_disparity;
                end
                compared++;
                if (tx_if.tx_even !== ev_m) begin
                    mismatched++;
                    $display("FAIL random frame %0d tx_even: got %b expected %b", f, tx_if.tx_even, ev_m);
                    ev_m = tx_if.tx_even;
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_idle;
        test_frame_even;
        test_frame_odd;
        test_data_codes;
        test_back_to_back;
        test_errprop;
        test_reset_midframe;
        test_random_frames;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
